// File: rtl/ahb_lite_mem_slave.sv
// ahb_lite_mem_slave: AHB-Lite responder backed by a word memory, with programmable wait states
// and the two-cycle ERROR response for illegal accesses.
module ahb_lite_mem_slave #(
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        Hresetn,
  input  logic        Hsel,
  input  logic [31:0] Haddr,
  input  logic        Hwrite,
  input  logic [2:0]  Hsize,
  input  logic [2:0]  Hburst,
  input  logic [1:0]  Htrans,
  input  logic [31:0] HWdata,
  input  logic        HREADY,
  output logic        Hready,
  output logic        Hresp,
  output logic [31:0] HRdata
);
  localparam int AW = $clog2(MEM_WORDS);
  typedef enum logic [2:0] {S_READY, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
  state_t r_state, w_state_next;
  logic [2:0] r_cnt, w_cnt_next;
  logic [AW+1:0] r_addr;
  logic r_write;
  logic [1:0] r_size;
  logic [31:0] r_mem [MEM_WORDS];
  logic w_acc, w_illegal, w_unused;
  logic [3:0] w_be;
  logic [AW-1:0] w_idx;
  assign w_unused = ^{Hburst, Htrans[0]};
  assign Hready = (r_state == S_READY) || (r_state == S_DATA) || (r_state == S_ERR2);
  assign Hresp = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign w_acc = Hsel && Htrans[1] && HREADY && Hready;
  assign w_illegal = Hsize[2] || (Hsize[1:0] == 2'b11) || (Hsize[1:0] == 2'b01 && Haddr[0]) ||
                     (Hsize[1:0] == 2'b10 && Haddr[1:0] != 2'b00) || ((Haddr >> (AW + 2)) != 32'd0);
  assign w_idx = r_addr[AW+1:2];
  assign w_be = r_size == 2'd0 ? 4'b0001 << r_addr[1:0] :
                r_size == 2'd1 ? (r_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  // Memory is written at the edge closing the write's data phase, so a read right behind it sees the merged word.
  assign HRdata = (r_state == S_DATA && !r_write) ? r_mem[w_idx] : 32'h0;
  always_comb begin
    w_state_next = r_state;
    w_cnt_next = r_cnt;
    if (r_state == S_WAIT) begin
      w_state_next = r_cnt == 3'd0 ? S_DATA : S_WAIT;
      w_cnt_next = r_cnt == 3'd0 ? r_cnt : r_cnt - 3'd1;
    end else if (r_state == S_ERR1) begin
      w_state_next = S_ERR2;
    end else if (w_acc) begin
      w_state_next = w_illegal ? S_ERR1 : (WAIT_STATES > 0 ? S_WAIT : S_DATA);
      w_cnt_next = (!w_illegal && WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
    end else begin
      w_state_next = S_READY;
    end
  end
  always_ff @(posedge clk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state <= S_READY;
      r_cnt <= 3'd0;
      r_addr <= '0;
      r_write <= 1'b0;
      r_size <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt <= w_cnt_next;
      if (w_acc) begin
        r_addr <= Haddr[AW+1:0];
        r_write <= Hwrite;
        r_size <= Hsize[1:0];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (r_state == S_DATA && r_write)
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= HWdata[8*i +: 8];
  end
endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// tb_ahb_lite_mem_slave: three responders (0, 1 and 3 wait states) behind one master; a byte-array
// reference model feeds a scoreboard that a passive bus monitor drains on every completed data phase.
module tb_ahb_lite_mem_slave;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam int MEM_BYTES = 1024;
  typedef struct packed {logic err; logic rd; logic [31:0] rdata;} exp_t;

  logic clk = 1'b0, hresetn = 1'b0;
  logic hsel_bus = 1'b0, hwrite_bus = 1'b0;
  logic [31:0] haddr_bus = '0, hwdata_bus = '0, pend = '0;
  logic [2:0] hsize_bus = '0, hburst_bus = '0;
  logic [1:0] htrans_bus = IDLE;
  logic hsel_v [3];
  logic dut_ready [3], dut_resp [3];
  logic [31:0] dut_rdata [3];
  logic hready_bus, resp_bus;
  logic [31:0] rdata_bus;
  int cur = 0, n_chk = 0, n_pass = 0;
  logic [7:0] mem_b [3][MEM_BYTES];
  exp_t sb[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign hsel_v[g] = hsel_bus && (cur == g);
    ahb_lite_mem_slave #(.MEM_WORDS(256), .WAIT_STATES(g == 2 ? 3 : g)) u_dut (
      .clk(clk), .Hresetn(hresetn), .Hsel(hsel_v[g]), .Haddr(haddr_bus), .Hwrite(hwrite_bus),
      .Hsize(hsize_bus), .Hburst(hburst_bus), .Htrans(htrans_bus), .HWdata(hwdata_bus),
      .HREADY(hready_bus), .Hready(dut_ready[g]), .Hresp(dut_resp[g]), .HRdata(dut_rdata[g]));
  end
  assign hready_bus = dut_ready[cur];
  assign resp_bus = dut_resp[cur];
  assign rdata_bus = dut_rdata[cur];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (dut %0d, t=%0t)", name, got, want, cur, $time);
  endtask

  function automatic int ws_of(input int k);
    return k == 2 ? 3 : k;
  endfunction

  function automatic bit legal(input logic [31:0] a, input logic [2:0] sz);
    return sz <= 3'd2 && (a % (32'd1 << sz)) == 32'd0 && a < 32'(MEM_BYTES);
  endfunction

  // Drives one address phase (holding it while the slave stalls); the previous write's data rides along.
  task automatic issue(input logic [1:0] tr, input logic sel, input logic [31:0] a, input logic w,
                       input logic [2:0] sz, input logic [31:0] d, input bit commit = 1'b1,
                       input bit use_want = 1'b0, input logic [31:0] want = 32'h0);
    exp_t e;
    int n, ai, wa;
    hwdata_bus = pend;
    pend = (w && tr[1] && sel) ? d : 32'h0;
    hsel_bus = sel; htrans_bus = tr; haddr_bus = a; hwrite_bus = w; hsize_bus = sz;
    hburst_bus = 3'($urandom_range(0, 1));
    if (tr[1] && sel) begin
      e.err = !legal(a, sz);
      e.rd = !w;
      e.rdata = 32'h0;
      if (!e.err) begin
        ai = int'(a);
        wa = ai & ~3;
        if (w && commit)
          for (int b = 0; b < (1 << sz); b++) mem_b[cur][ai + b] = d[8*((ai + b) % 4) +: 8];
        if (!w) e.rdata = {mem_b[cur][wa+3], mem_b[cur][wa+2], mem_b[cur][wa+1], mem_b[cur][wa]};
      end
      if (use_want) e.rdata = want;
      sb.push_back(e);
    end
    n = 0;
    @(negedge clk);
    while (!hready_bus && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("hready_timeout", 64'(n), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue(IDLE, 1'b1, 32'h0, 1'b0, 3'd0, 32'h0);
  endtask
  task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    issue(NONSEQ, 1'b1, a, 1'b1, sz, d);
  endtask
  task automatic rd_want(input logic [31:0] a, input logic [31:0] want);
    issue(NONSEQ, 1'b1, a, 1'b0, 3'd2, 32'h0, 1'b1, 1'b1, want);
  endtask

  // Passive monitor: tracks data phases from the bus and compares each completion against the scoreboard.
  exp_t mon_e;
  bit in_dp = 1'b0, low_bad = 1'b0;
  int waits = 0;
  always @(negedge clk) begin
    if (!hresetn) begin
      in_dp = 1'b0;
    end else if (in_dp && !hready_bus) begin
      waits++;
      if (resp_bus !== mon_e.err || rdata_bus !== 32'h0) low_bad = 1'b1;
    end else begin
      if (in_dp) begin
        chk("resp", 64'(resp_bus), 64'(mon_e.err));
        chk("waits", 64'(waits), 64'(mon_e.err ? 1 : ws_of(cur)));
        chk("low_phase", 64'(low_bad), 64'(0));
        if (mon_e.err || mon_e.rd) chk("rdata", 64'(rdata_bus), 64'(mon_e.rdata));
      end else begin
        chk("idle", 64'({hready_bus, resp_bus, rdata_bus}), 64'({1'b1, 1'b0, 32'h0}));
      end
      in_dp = hsel_bus && htrans_bus[1] && hready_bus;
      if (in_dp) begin
        waits = 0;
        low_bad = 1'b0;
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'(1), 64'(0));
          in_dp = 1'b0;
        end else mon_e = sb.pop_front();
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] tr;
    logic [2:0] sz;
    logic [31:0] a;
    int r;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk("reset_outputs", 64'({dut_ready[k], dut_resp[k], dut_rdata[k]}), 64'({1'b1, 1'b0, 32'h0}));
    #1 hresetn = 1'b1;
    @(posedge clk);
    #1;
    // single write/read, one wait state
    cur = 1;
    wr(32'h10, 3'd2, 32'hDEADBEEF);
    idle();
    rd_want(32'h10, 32'hDEADBEEF);
    idle();
    // byte and halfword lanes
    wr(32'h20, 3'd2, 32'h11223344);
    wr(32'h21, 3'd0, 32'h0000AA00);
    wr(32'h22, 3'd1, 32'hBBCC0000);
    rd_want(32'h20, 32'hBBCCAA44);
    idle();
    // INCR burst with BUSY, zero wait states
    cur = 0;
    issue(NONSEQ, 1'b1, 32'h40, 1'b1, 3'd2, 32'd1);
    issue(SEQ, 1'b1, 32'h44, 1'b1, 3'd2, 32'd2);
    issue(BUSY, 1'b1, 32'h48, 1'b1, 3'd2, 32'd0);
    issue(SEQ, 1'b1, 32'h48, 1'b1, 3'd2, 32'd3);
    rd_want(32'h40, 32'd1);
    issue(SEQ, 1'b1, 32'h44, 1'b0, 3'd2, 32'h0, 1'b1, 1'b1, 32'd2);
    issue(SEQ, 1'b1, 32'h48, 1'b0, 3'd2, 32'h0, 1'b1, 1'b1, 32'd3);
    idle();
    // error responses leave memory intact and the next transfer is OKAY
    cur = 1;
    wr(32'h00, 3'd2, 32'h0BADF00D);
    wr(32'h02, 3'd2, 32'hFFFFFFFF);
    rd_want(32'h00, 32'h0BADF00D);
    wr(32'h10, 3'd3, 32'hFFFFFFFF);
    rd_want(32'h10, 32'hDEADBEEF);
    wr(32'd1024, 3'd2, 32'hFFFFFFFF);
    issue(NONSEQ, 1'b1, 32'd1024, 1'b0, 3'd2, 32'h0);
    rd_want(32'h10, 32'hDEADBEEF);
    idle();
    // back-to-back write then read of the same word on every wait-state setting
    for (int k = 0; k < 3; k++) begin
      cur = k;
      wr(32'h30, 3'd2, 32'h5A5A5A5A);
      rd_want(32'h30, 32'h5A5A5A5A);
      idle();
    end
    // reset during the second wait cycle of a write discards it
    cur = 2;
    wr(32'h50, 3'd2, 32'hCAFEF00D);
    idle();
    issue(NONSEQ, 1'b1, 32'h50, 1'b1, 3'd2, 32'h12345678, 1'b0);
    hwdata_bus = 32'h12345678;
    htrans_bus = IDLE;
    @(posedge clk);
    #2 hresetn = 1'b0;
    #1 chk("reset_async", 64'({dut_ready[2], dut_resp[2], dut_rdata[2]}), 64'({1'b1, 1'b0, 32'h0}));
    @(negedge clk);
    #1 hresetn = 1'b1;
    pend = 32'h0;
    @(posedge clk);
    #1;
    rd_want(32'h50, 32'hCAFEF00D);
    idle();
    // randomized traffic against the model
    for (int k = 0; k < 3; k++) begin
      cur = k;
      for (int i = 0; i < 64; i++) wr(32'h100 + 32'(4 * i), 3'd2, $urandom);
      for (int i = 0; i < 80; i++) begin
        r = $urandom_range(0, 99);
        sz = 3'($urandom_range(0, 2));
        a = (32'h100 + 32'($urandom_range(0, 255))) & ~((32'd1 << sz) - 32'd1);
        tr = $urandom_range(0, 1) ? NONSEQ : SEQ;
        if (r < 8) tr = IDLE;
        else if (r < 12) tr = BUSY;
        else if (r < 24) begin
          case ($urandom_range(0, 2))
            0: sz = 3'($urandom_range(3, 7));
            1: begin sz = 3'd2; a = a | 32'($urandom_range(1, 3)); end
            default: a = 32'h400 + 32'(4 * $urandom_range(0, 1000));
          endcase
        end
        issue(tr, r >= 16 || r < 12, a, 1'($urandom_range(0, 1)), sz, $urandom);
      end
      idle();
      idle();
    end
    idle();
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
